// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: RAW stalls, branch flushes and memory-wait freezes.
// Optional macro HAZARD_FWD_EN limits RAW stalls to load-use hazards.
module hazard_ctrl #(
    parameter int REG_W        = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_WAIT     = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_front,
    output logic             freeze_back,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam int FC_W   = 4;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [FC_W-1:0]   FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    state_t            state, state_nxt;
    logic [FC_W-1:0]   flush_cnt, flush_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              raw;
    logic              mem_stall;

    assign mem_stall = mem_req & ~mem_ready;

`ifdef HAZARD_FWD_EN
    // Everything but a load result in EXE is covered by the forwarding paths.
    logic unused_mem;
    assign unused_mem = mem_wb_en ^ (^mem_dest);
    assign raw = id_valid & exe_mem_r_en & exe_wb_en &
                 ((exe_dest == id_src1) | (id_two_src & (exe_dest == id_src2)));
`else
    logic src1_hit, src2_hit;
    logic unused_load;
    assign unused_load = exe_mem_r_en;
    assign src1_hit = (exe_wb_en & (exe_dest == id_src1)) | (mem_wb_en & (mem_dest == id_src1));
    assign src2_hit = (exe_wb_en & (exe_dest == id_src2)) | (mem_wb_en & (mem_dest == id_src2));
    assign raw      = id_valid & (src1_hit | (id_two_src & src2_hit));
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            stall_count <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            if (freeze_front && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
            if ((state_nxt == MEM_WAIT) && (wait_cnt_nxt == WAIT_MAX))
                mem_timeout <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        wait_cnt_nxt  = wait_cnt;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_ONE;
                end else if (branch_taken && (FLUSH_CYCLES > 1)) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FC_RELOAD;
                end
            end
            MEM_WAIT: begin
                // A branch seen here is ignored: EXE is frozen and re-presents it.
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt != WAIT_MAX) begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            FLUSH: begin
                if (mem_stall) begin
                    state_nxt     = MEM_WAIT;
                    wait_cnt_nxt  = WAIT_ONE;
                    flush_cnt_nxt = '0;
                end else if (branch_taken) begin
                    flush_cnt_nxt = FC_RELOAD;
                end else if (flush_cnt <= FC_W'(1)) begin
                    state_nxt     = RUN;
                    flush_cnt_nxt = '0;
                end else begin
                    flush_cnt_nxt = flush_cnt - 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        freeze_front = 1'b0;
        freeze_back  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        if (rst_n) begin
            unique case (state)
                RUN: begin
                    if (mem_stall) begin
                        freeze_front = 1'b1;
                        freeze_back  = 1'b1;
                    end else if (branch_taken) begin
                        flush_if_id  = 1'b1;
                        flush_id_exe = 1'b1;
                    end else if (raw) begin
                        freeze_front = 1'b1;
                        flush_id_exe = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    freeze_front = 1'b1;
                    freeze_back  = 1'b1;
                end
                FLUSH: begin
                    if (mem_stall) begin
                        freeze_front = 1'b1;
                        freeze_back  = 1'b1;
                    end else begin
                        flush_if_id  = 1'b1;
                        flush_id_exe = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (3-cycle flush / long timeout,
// 1-cycle flush / short timeout with a 3-bit stall counter) share one stimulus.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam logic R = 1'b0;
`else
    localparam logic R = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       branch_taken, mem_req, mem_ready;

    logic        a_ff, a_fb, a_fi, a_fe, a_to;
    logic [15:0] a_cnt;
    logic        b_ff, b_fb, b_fi, b_fe, b_to;
    logic [2:0]  b_cnt;

    int checks = 0;
    int errors = 0;
    int sa = 0;
    int sb = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(4), .FLUSH_CYCLES(3), .MAX_WAIT(64), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_front(a_ff), .freeze_back(a_fb), .flush_if_id(a_fi), .flush_id_exe(a_fe),
        .stall_count(a_cnt), .mem_timeout(a_to)
    );

    hazard_ctrl #(.REG_W(4), .FLUSH_CYCLES(1), .MAX_WAIT(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_front(b_ff), .freeze_back(b_fb), .flush_if_id(b_fi), .flush_id_exe(b_fe),
        .stall_count(b_cnt), .mem_timeout(b_to)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Control vectors are {freeze_front, freeze_back, flush_if_id, flush_id_exe}.
    task automatic chk_a(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, a_ff, a_fb, a_fi, a_fe}, {28'd0, exp});
    endtask

    task automatic chk_b(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, b_ff, b_fb, b_fi, b_fe}, {28'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
        id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk_a("rst_ctrl_a", 4'b0000);
        chk_b("rst_ctrl_b", 4'b0000);
        check("rst_cnt_a", a_cnt, 0);
        check("rst_to_a", a_to, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // RAW hazards
        id_valid = 1; id_src1 = 3; exe_wb_en = 1; exe_dest = 3;
        #1 chk_a("raw_exe", {R, 1'b0, 1'b0, R});
        tick(); sa += R; sb = sat7(sb + R);
        clear_inputs();
        id_valid = 1; id_two_src = 1; id_src1 = 0; id_src2 = 5;
        exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 5;
        #1 chk_a("load_use_src2", 4'b1001);
        chk_b("load_use_src2_b", 4'b1001);
        tick(); sa += 1; sb = sat7(sb + 1);
        id_two_src = 0;
        #1 chk_a("src2_unused", 4'b0000);
        tick();
        clear_inputs();
        id_valid = 1; id_src1 = 0; mem_wb_en = 1; mem_dest = 0;
        #1 chk_a("raw_mem_r0", {R, 1'b0, 1'b0, R});
        tick(); sa += R; sb = sat7(sb + R);
        id_valid = 0;
        #1 chk_a("no_valid", 4'b0000);
        tick();
        clear_inputs();
        #1 check("cnt_after_raw_a", a_cnt, sa);
        check("cnt_after_raw_b", b_cnt, sb);

        // Branch flush: 3 cycles on a, 1 cycle on b
        branch_taken = 1;
        #1 chk_a("br_c0", 4'b0011);
        chk_b("br_c0_b", 4'b0011);
        tick(); branch_taken = 0;
        #1 chk_a("br_c1", 4'b0011);
        chk_b("br_c1_b", 4'b0000);
        tick();
        #1 chk_a("br_c2", 4'b0011);
        tick();
        #1 chk_a("br_done", 4'b0000);

        // Branch while flushing reloads the counter
        branch_taken = 1;
        tick();
        #1 chk_a("reload_c1", 4'b0011);
        tick(); branch_taken = 0;
        #1 chk_a("reload_c2", 4'b0011);
        tick();
        #1 chk_a("reload_c3", 4'b0011);
        tick();
        #1 chk_a("reload_done", 4'b0000);

        // Memory stall during flush discards the remaining flush
        branch_taken = 1;
        tick(); branch_taken = 0; mem_req = 1; mem_ready = 0;
        #1 chk_a("fl_memstall", 4'b1100);
        chk_b("fl_memstall_b", 4'b1100);
        tick(); mem_ready = 1;
        #1 chk_a("fl_memready", 4'b1100);
        tick(); mem_req = 0; mem_ready = 0;
        #1 chk_a("fl_discarded", 4'b0000);
        chk_b("fl_discarded_b", 4'b0000);
        sa += 2; sb = sat7(sb + 2);

        // Memory wait: 5 not-ready cycles then ready
        mem_req = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk_a($sformatf("t4_wait%0d", i), 4'b1100);
            tick();
            check($sformatf("t4_to_b%0d", i), b_to, (i >= 3));
        end
        mem_ready = 1;
        #1 chk_a("t4_ready", 4'b1100);
        chk_b("t4_ready_b", 4'b1100);
        tick(); mem_req = 0; mem_ready = 0;
        #1 chk_a("t4_after", 4'b0000);
        sa += 6; sb = sat7(sb + 6);
        check("t4_cnt_a", a_cnt, sa);
        check("t4_cnt_b_sat", b_cnt, sb);
        check("t4_to_a", a_to, 0);
        check("t4_to_b_sticky", b_to, 1);

        // Simultaneous memory stall, branch and RAW
        mem_req = 1; mem_ready = 0; branch_taken = 1;
        id_valid = 1; id_src1 = 3; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 3;
        #1 chk_a("t6_all", 4'b1100);
        chk_b("t6_all_b", 4'b1100);
        tick(); mem_ready = 1;
        #1 chk_a("t6_ready", 4'b1100);
        tick(); mem_req = 0; mem_ready = 0;
        #1 chk_a("t6_branch", 4'b0011);
        chk_b("t6_branch_b", 4'b0011);
        tick(); clear_inputs();
        #1 chk_a("t6_tail", 4'b0011);
        chk_b("t6_tail_b", 4'b0000);
        tick(); tick();
        #1 chk_a("t6_done", 4'b0000);
        sa += 2; sb = sat7(sb + 2);
        check("t6_cnt_a", a_cnt, sa);

        // Asynchronous reset in the middle of a memory wait
        mem_req = 1;
        tick();
        #1 chk_a("t1_prewait", 4'b1100);
        rst_n = 1'b0;
        #1 chk_a("t1_rst_ctrl", 4'b0000);
        chk_b("t1_rst_ctrl_b", 4'b0000);
        check("t1_rst_cnt_a", a_cnt, 0);
        check("t1_rst_to_b", b_to, 0);
        mem_req = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk_a("t1_run", 4'b0000);
        tick();
        check("t1_cnt_a", a_cnt, 0);
        sa = 0; sb = 0;

        // Timeout: 10 not-ready cycles, flag rises on the 4th edge on b
        mem_req = 1; mem_ready = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("t5_to_b%0d", i), b_to, (i >= 4));
        end
        check("t5_to_a", a_to, 0);
        mem_ready = 1;
        tick(); mem_req = 0; mem_ready = 0;
        #1 chk_a("t5_after", 4'b0000);
        sa += 11; sb = sat7(sb + 11);
        check("t5_to_b_held", b_to, 1);
        check("t5_cnt_a", a_cnt, sa);
        check("t5_cnt_b", b_cnt, sb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
